iir_coef_ctrl: RTL and testbench
================================

Name: iir_coef_ctrl

Overview:
- Runtime coefficient configuration and sequencing controller for the team's IIR filter datapath, in the AXI-stream path directly in front of a coefficient-programmable IIR instance.
- Holds a shadow coefficient bank written over a simple register port and an active bank driven to the filter.
- On commit it stalls new samples, drains in-flight samples, swaps banks atomically, then pulses a filter state-clear before resuming traffic.

Parameters:
- N, 4, filter order; N+1 feed-forward (b) and N feedback (a) coefficients.
- IW, 8, sample width.
- CW, 8, coefficient width, signed.
- CFW, 6, coefficient fraction bits; reset value of b[0] is 1<<CFW (passthrough).
- MAX_INFLIGHT, 4, maximum samples in the filter pipeline; sets in-flight counter width to $clog2(MAX_INFLIGHT+1).
- FLUSH_CYC, N+1, cycles filt_clr is held high.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr_en  in  1  shadow write strobe
- cfg_wr_addr  in  $clog2(2N+1)  0..N selects b[0..N]; N+1..2N selects a[0..N-1]
- cfg_wr_data  in  CW  signed coefficient
- cfg_commit  in  1  request bank swap
- cfg_busy  out  1  high in any state other than IDLE
- cfg_done  out  1  one-cycle pulse on return to IDLE after a swap
- cfg_err  out  1  sticky; set by a write to address >2N or by a commit while busy
- cfg_err_clr  in  1  clears cfg_err
- s_axis_tdata  in  IW  upstream samples
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_tdata  out  IW  samples to filter
- m_axis_tvalid  out  1  valid to filter
- m_axis_tready  in  1  filter ready
- filt_o_tvalid  in  1  filter output valid (monitor)
- filt_o_tready  in  1  downstream ready at filter output (monitor)
- coef_b  out  (N+1)*CW  active b bank, flattened, b[0] in LSBs
- coef_a  out  N*CW  active a bank, flattened, a[0] in LSBs
- filt_clr  out  1  synchronous state clear to filter

Behaviour:
- Reset values:
  - State IDLE; cfg_busy=0, cfg_done=0, cfg_err=0, filt_clr=0; in-flight count 0.
  - Both banks all zero except b[0]=1<<CFW.
  - m_axis_tvalid=0 and s_axis_tready=0 during reset.
- Stream gating is combinational with zero latency:
  - m_axis_tdata = s_axis_tdata.
  - m_axis_tvalid = s_axis_tvalid & (state==IDLE).
  - s_axis_tready = m_axis_tready & (state==IDLE).
- In-flight counter:
  - Increments on m_axis_tvalid & m_axis_tready; decrements on filt_o_tvalid & filt_o_tready.
  - Both in the same cycle: count unchanged.
  - Saturates at 0 and at MAX_INFLIGHT; an underflow attempt sets cfg_err.
- Shadow writes:
  - Accepted in every state; take effect at the clock edge.
  - Out-of-range address: write ignored, cfg_err set.
- State machine:
  - IDLE: cfg_commit → DRAIN next cycle. A transfer in the same cycle as the commit is accepted and counted.
  - DRAIN: stays while count≠0; count==0 → SWAP. DRAIN has no timeout; it waits indefinitely under downstream backpressure.
  - SWAP (1 cycle): active ← shadow at the end of the cycle. A shadow write in the same cycle lands in shadow only and is not copied.
  - FLUSH: filt_clr=1 for exactly FLUSH_CYC cycles, down-counter, then → IDLE with cfg_done=1 for 1 cycle.
- Commit handling:
  - cfg_commit while not IDLE: ignored, cfg_err set, no queuing.
  - cfg_commit in the IDLE cycle that follows FLUSH is honoured.
- cfg_err_clr and a new error in the same cycle: set wins.
- Reset asserted mid-operation: all state returns to reset values immediately; the shadow bank is also reset; a pending swap is lost.
- Commit-to-traffic latency with an empty pipeline: commit at cycle t; DRAIN t+1; SWAP t+2; FLUSH t+3..t+2+FLUSH_CYC; IDLE and cfg_done at t+3+FLUSH_CYC.

Decomposition:
- Package iir_ctrl_pkg holds:
  - state enum {IDLE, DRAIN, SWAP, FLUSH};
  - address-decode constants B_BASE=0 and A_BASE=N+1 as functions of N;
  - reset-bank constant function (b[0]=1<<CFW, all others 0).
- One sub-module, iir_inflight_cnt: up/down saturating counter with underflow flag.

Test Plan:
- Reset, then stream 0x10, 0x20 with m_axis_tready=1 → m_axis_tdata passes unchanged; coef_b=0x40 in LSBs, all other bytes 0.
- Write b0..b4=0x20 and a0=0xF0, commit with empty pipeline → DRAIN 1 cycle, SWAP, filt_clr high 5 cycles, cfg_done at t+8; coef_b=0x2020202020, coef_a[7:0]=0xF0.
- 3 samples in flight, commit, filt_o_tready=0 for 10 cycles → s_axis_tready=0 throughout; SWAP only after the 3 output handshakes complete.
- Commit during FLUSH → cfg_err=1, no second swap; cfg_err_clr → cfg_err=0.
- Write addr 9 (N=4) → cfg_err=1, both banks unchanged; shadow write in the SWAP cycle → active bank lacks it until the next commit.
- rst_n low during FLUSH → filt_clr=0 and cfg_busy=0 immediately; banks return to passthrough.

Source files
------------

// File: rtl/iir_ctrl_pkg.sv
// Shared types and constants for the IIR coefficient controller.
package iir_ctrl_pkg;

  // Sequencing states of the coefficient controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_e;

  // Feed-forward coefficients start at address 0.
  localparam int B_BASE = 0;

  // Feedback coefficients follow the N+1 feed-forward ones.
  function automatic int a_base_addr(input int n);
    return n + 1;
  endfunction

  // Highest legal register address for an order-n filter.
  function automatic int addr_max(input int n);
    return 2 * n;
  endfunction

  // Passthrough bank: b[0] = 1.0 in the coefficient's fixed-point format.
  function automatic logic [31:0] reset_coef(input int idx, input int cfw);
    return (idx == 0) ? (32'd1 << cfw) : 32'd0;
  endfunction

endpackage

// File: rtl/iir_inflight_cnt.sv
// Up/down saturating counter of samples inside the filter pipeline.
module iir_inflight_cnt #(
  parameter int MAX_COUNT = 4,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: simultaneous inc/dec cancel; both ends saturate.
  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (count_q != CNT_W'(MAX_COUNT)) begin
        count_d = count_q + 1'b1;
      end
    end else if (dec && !inc) begin
      if (count_q == '0) begin
        underflow = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/iir_coef_ctrl.sv
// Coefficient bank controller: shadow/active banks, stream gating and
// commit sequencing (drain, atomic swap, filter state clear).
module iir_coef_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int N            = 4,
  parameter int IW           = 8,
  parameter int CW           = 8,
  parameter int CFW          = 6,
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYC    = N + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_wr_en,
  input  logic [$clog2(2*N+1)-1:0]  cfg_wr_addr,
  input  logic [CW-1:0]             cfg_wr_data,
  input  logic                      cfg_commit,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  input  logic                      cfg_err_clr,
  input  logic [IW-1:0]             s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [IW-1:0]             m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      filt_o_tvalid,
  input  logic                      filt_o_tready,
  output logic [(N+1)*CW-1:0]       coef_b,
  output logic [N*CW-1:0]           coef_a,
  output logic                      filt_clr
);

  localparam int AW     = $clog2(2*N+1);
  localparam int NC     = 2*N + 1;
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int FW     = $clog2(FLUSH_CYC + 1);
  localparam int A_BASE = a_base_addr(N);
  localparam int A_MAX  = addr_max(N);

  ctrl_state_e       state_q, state_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CW-1:0]     shadow_q [NC];
  logic [CW-1:0]     shadow_d [NC];
  logic [CW-1:0]     active_q [NC];
  logic [CW-1:0]     active_d [NC];
  logic [CW-1:0]     rst_bank [NC];
  logic [CNT_W-1:0]  inflight;
  logic              underflow;
  logic              stream_open;
  logic              addr_oob;
  logic              commit_err;

  // Passthrough reset image, one coefficient per register address.
  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_rst_bank
      localparam logic [31:0] RST_FULL = reset_coef(gi - B_BASE, CFW);
      assign rst_bank[gi] = RST_FULL[CW-1:0];
    end
  endgenerate

  // Traffic only flows while idle and out of reset; data is never touched.
  assign stream_open   = (state_q == IDLE) && rst_n;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid && stream_open;
  assign s_axis_tready = m_axis_tready && stream_open;

  iir_inflight_cnt #(
    .MAX_COUNT (MAX_INFLIGHT),
    .CNT_W     (CNT_W)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (m_axis_tvalid && m_axis_tready),
    .dec       (filt_o_tvalid && filt_o_tready),
    .count     (inflight),
    .underflow (underflow)
  );

  // Sequencer: IDLE -> DRAIN -> SWAP -> FLUSH (FLUSH_CYC cycles) -> IDLE.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d     = FLUSH;
        flush_cnt_d = FW'(FLUSH_CYC - 1);
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error: a new error in the same cycle as a clear still sets it.
  always_comb begin
    addr_oob   = cfg_wr_en && (cfg_wr_addr > AW'(A_MAX));
    commit_err = cfg_commit && (state_q != IDLE);
    err_d      = err_q;
    if (addr_oob || commit_err || underflow) begin
      err_d = 1'b1;
    end else if (cfg_err_clr) begin
      err_d = 1'b0;
    end
  end

  // Banks: swap copies the pre-write shadow, so a same-cycle write stays shadow-only.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (state_q == SWAP) begin
      active_d = shadow_q;
    end
    for (int i = 0; i < NC; i++) begin
      if (cfg_wr_en && (cfg_wr_addr == AW'(i))) begin
        shadow_d[i] = cfg_wr_data;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Coefficient bank registers; reset restores the passthrough image in both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        shadow_q[i] <= rst_bank[i];
        active_q[i] <= rst_bank[i];
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Flatten the active bank onto the filter coefficient buses.
  generate
    for (genvar gi = 0; gi < N + 1; gi++) begin : g_coef_b
      assign coef_b[gi*CW +: CW] = active_q[B_BASE + gi];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_coef_a
      assign coef_a[gi*CW +: CW] = active_q[A_BASE + gi];
    end
  endgenerate

  assign cfg_busy = (state_q != IDLE);
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign filt_clr = (state_q == FLUSH);

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Self-checking bench for iir_coef_ctrl: vector table, directed corner
// sequences and a randomized phase against a timestamp-based reference model.
module tb_iir_coef_ctrl;

  localparam int N         = 4;
  localparam int IW        = 8;
  localparam int CW        = 8;
  localparam int FLUSH_CYC = N + 1;
  localparam int MAXF      = 4;
  localparam int NC        = 2*N + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_wr_en;
  logic [3:0]          cfg_wr_addr;
  logic [CW-1:0]       cfg_wr_data;
  logic                cfg_commit;
  logic                cfg_busy, cfg_done, cfg_err;
  logic                cfg_err_clr;
  logic [IW-1:0]       s_axis_tdata;
  logic                s_axis_tvalid, s_axis_tready;
  logic [IW-1:0]       m_axis_tdata;
  logic                m_axis_tvalid, m_axis_tready;
  logic                filt_o_tvalid, filt_o_tready;
  logic [(N+1)*CW-1:0] coef_b;
  logic [N*CW-1:0]     coef_a;
  logic                filt_clr;

  iir_coef_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .filt_o_tvalid(filt_o_tvalid), .filt_o_tready(filt_o_tready),
    .coef_b(coef_b), .coef_a(coef_a), .filt_clr(filt_clr)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: commit/swap tracked as cycle timestamps.
  int        cyc;
  bit        m_drain;
  int        m_swap;
  int        m_inflight;
  bit        m_err;
  logic [7:0] m_shadow [NC];
  logic [7:0] m_active [NC];

  // Sampled DUT outputs of the most recent step.
  logic s_busy, s_done, s_clr, s_err, s_mtv, s_str;
  logic [(N+1)*CW-1:0] s_cb;

  task automatic model_reset();
    m_drain = 0; m_swap = -1; m_inflight = 0; m_err = 0;
    for (int i = 0; i < NC; i++) begin
      m_shadow[i] = (i == 0) ? 8'h40 : 8'h00;
      m_active[i] = (i == 0) ? 8'h40 : 8'h00;
    end
  endtask

  function automatic bit model_busy();
    return m_drain || (m_swap >= 0 && cyc >= m_swap && cyc <= m_swap + FLUSH_CYC);
  endfunction

  // One clock cycle: compare at negedge, advance model at posedge.
  task automatic step();
    bit busy_e, clr_e, done_e, tv_e, tr_e, inc, dec, err_set;
    logic [(N+1)*CW-1:0] eb;
    logic [N*CW-1:0] ea;
    int old_inf;
    @(negedge clk);
    busy_e = rst_n && model_busy();
    clr_e  = rst_n && m_swap >= 0 && cyc > m_swap && cyc <= m_swap + FLUSH_CYC;
    done_e = rst_n && m_swap >= 0 && cyc == m_swap + FLUSH_CYC + 1;
    tv_e   = s_axis_tvalid && !busy_e && rst_n;
    tr_e   = m_axis_tready && !busy_e && rst_n;
    for (int i = 0; i <= N; i++) eb[i*CW +: CW] = m_active[i];
    for (int i = 0; i < N; i++)  ea[i*CW +: CW] = m_active[N+1+i];
    check("busy", cfg_busy, busy_e);
    check("done", cfg_done, done_e);
    check("filt_clr", filt_clr, clr_e);
    check("err", cfg_err, m_err);
    check("m_tvalid", m_axis_tvalid, tv_e);
    check("s_tready", s_axis_tready, tr_e);
    check("m_tdata", m_axis_tdata, s_axis_tdata);
    check("coef_b", coef_b, eb);
    check("coef_a", coef_a, ea);
    s_busy = cfg_busy; s_done = cfg_done; s_clr = filt_clr; s_err = cfg_err;
    s_mtv = m_axis_tvalid; s_str = s_axis_tready; s_cb = coef_b;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      inc = tv_e && m_axis_tready;
      dec = filt_o_tvalid && filt_o_tready;
      old_inf = m_inflight;
      err_set = (cfg_wr_en && cfg_wr_addr > 4'd8) || (cfg_commit && busy_e) ||
                (dec && !inc && old_inf == 0);
      if (err_set) m_err = 1;
      else if (cfg_err_clr) m_err = 0;
      if (inc && !dec && m_inflight < MAXF) m_inflight++;
      if (dec && !inc && m_inflight > 0) m_inflight--;
      if (m_drain && old_inf == 0) begin
        m_swap = cyc + 1;
        m_drain = 0;
      end
      if (cyc == m_swap) for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
      if (cfg_wr_en && cfg_wr_addr <= 4'd8) m_shadow[cfg_wr_addr] = cfg_wr_data;
      if (cfg_commit && !busy_e) m_drain = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    cfg_wr_en = 0; cfg_wr_addr = 0; cfg_wr_data = 0; cfg_commit = 0; cfg_err_clr = 0;
    s_axis_tdata = 0; s_axis_tvalid = 0; m_axis_tready = 0;
    filt_o_tvalid = 0; filt_o_tready = 0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    cfg_wr_en = 1; cfg_wr_addr = addr; cfg_wr_data = data;
    step();
    cfg_wr_en = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    step();
    cfg_commit = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (model_busy() && k < budget) begin
      step();
      k++;
    end
    check("wait_idle_bound", model_busy(), 1'b0);
  endtask

  task automatic wait_clr(input int budget);
    int k = 0;
    s_clr = 0;
    while (!s_clr && k < budget) begin
      step();
      k++;
    end
    check("wait_flush_bound", s_clr, 1'b1);
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       exp_mtv;
    logic       exp_str;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int clr_n, done_at;
    logic [2:0] seq;

    vecs[0] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'h20, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset state.
    cyc = 0;
    rst_n = 0;
    idle_inputs();
    model_reset();
    s_axis_tvalid = 1; m_axis_tready = 1;
    repeat (3) step();
    check("rst_s_tready", s_str, 1'b0);
    check("rst_m_tvalid", s_mtv, 1'b0);
    check("rst_coef_b", coef_b, 40'h40);
    check("rst_coef_a", coef_a, 32'h0);
    idle_inputs();
    rst_n = 1;
    step();

    // Stream gating vector table in IDLE.
    foreach (vecs[i]) begin
      s_axis_tvalid = vecs[i].sv; s_axis_tdata = vecs[i].sd; m_axis_tready = vecs[i].mr;
      step();
      check($sformatf("vec%0d_m_tvalid", i), s_mtv, vecs[i].exp_mtv);
      check($sformatf("vec%0d_s_tready", i), s_str, vecs[i].exp_str);
    end
    idle_inputs();
    filt_o_tvalid = 1; filt_o_tready = 1;
    for (int k = 0; k < 10 && m_inflight > 0; k++) step();
    idle_inputs();
    step();
    check("no_err_after_drain", s_err, 1'b0);

    // Commit with empty pipeline: exact latency.
    for (int i = 0; i <= N; i++) wr(4'(i), 8'h20);
    wr(4'd5, 8'hF0);
    commit();
    clr_n = 0; done_at = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (s_clr) clr_n++;
      if (s_done) done_at = k;
    end
    check("flush_len", clr_n, 5);
    check("done_latency", done_at, 8);
    step();
    check("swap_coef_b", s_cb, 40'h2020202020);
    check("swap_coef_a0", coef_a[7:0], 8'hF0);

    // Three samples in flight, downstream stalled.
    m_axis_tready = 1; s_axis_tvalid = 1;
    for (int k = 0; k < 3; k++) begin
      s_axis_tdata = 8'($urandom);
      step();
    end
    s_axis_tvalid = 0;
    wr(4'd1, 8'h11);
    commit();
    s_axis_tvalid = 1; filt_o_tvalid = 1; filt_o_tready = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_s_tready", s_str, 1'b0);
      check("stall_no_clr", s_clr, 1'b0);
    end
    s_axis_tvalid = 0; filt_o_tready = 1;
    repeat (3) step();
    idle_inputs();
    step(); seq[2] = s_clr;
    step(); seq[1] = s_clr;
    step(); seq[0] = s_clr;
    check("post_drain_clr_seq", seq, 3'b001);
    wait_idle(20);
    check("drain_swap_b1", coef_b[15:8], 8'h11);

    // Commit during FLUSH: error, no queued swap.
    commit();
    wait_clr(10);
    commit();
    step();
    check("flush_commit_err", s_err, 1'b1);
    wait_idle(20);
    repeat (4) begin
      step();
      check("no_second_swap", s_busy, 1'b0);
    end
    cfg_err_clr = 1; step(); cfg_err_clr = 0;
    step();
    check("err_cleared", s_err, 1'b0);

    // Out-of-range write.
    wr(4'd9, 8'h77);
    step();
    check("oob_err", s_err, 1'b1);
    check("oob_coef_b", s_cb, 40'h2020201120);
    cfg_err_clr = 1; step(); cfg_err_clr = 0;

    // Shadow write in the SWAP cycle stays out of the active bank.
    commit();
    for (int k = 0; k < 20 && m_swap != cyc; k++) step();
    check("swap_cycle_found", m_swap, cyc);
    wr(4'd2, 8'h55);
    wait_idle(20);
    check("swap_write_excluded", coef_b[23:16], 8'h20);
    commit();
    wait_idle(20);
    check("swap_write_next_commit", coef_b[23:16], 8'h55);

    // Reset during FLUSH.
    commit();
    wait_clr(10);
    rst_n = 0;
    #1;
    check("rst_async_clr", filt_clr, 1'b0);
    check("rst_async_busy", cfg_busy, 1'b0);
    check("rst_async_coef_b", coef_b, 40'h40);
    check("rst_async_coef_a", coef_a, 32'h0);
    model_reset();
    s_axis_tvalid = 1; m_axis_tready = 1;
    repeat (2) step();
    rst_n = 1;
    idle_inputs();
    step();

    // Randomized traffic, writes, commits and clears.
    for (int k = 0; k < 3000; k++) begin
      s_axis_tvalid = 1'($urandom);
      s_axis_tdata  = 8'($urandom);
      m_axis_tready = 1'($urandom);
      filt_o_tvalid = 1'($urandom);
      filt_o_tready = 1'($urandom);
      cfg_wr_en     = ($urandom % 4) == 0;
      cfg_wr_addr   = 4'($urandom);
      cfg_wr_data   = 8'($urandom);
      cfg_commit    = ($urandom % 40) == 0;
      cfg_err_clr   = ($urandom % 10) == 0;
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
